cpu_instr_fetch_unit: RTL

//  Memory-side end of the program-counter address path: accepts a fetch address (the PC value) from the core,

---
 rtl/cpu_pkg.sv | 14 +
 rtl/cpu_instr_fetch_unit.sv | 139 +++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package cpu_pkg;

  typedef enum logic [2:0] {
    IFU_IDLE  = 3'd0,
    IFU_REQ   = 3'd1,
    IFU_WAIT  = 3'd2,
    IFU_HOLD  = 3'd3,
    IFU_DRAIN = 3'd4
  } ifu_state_e;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/cpu_instr_fetch_unit.sv
// Instruction fetch unit: one req/gnt/rvalid transaction at a time, result held for decode.
// Optional CPU_IFU_ALIGN_CHECK_EN: misaligned addresses fault locally with a NOP instead of going to memory.
//
// state     | meaning
// IFU_IDLE  | ready for a new fetch address
// IFU_REQ   | imem_req asserted, waiting for grant
// IFU_WAIT  | granted, waiting for read data
// IFU_HOLD  | instruction presented to decode
// IFU_DRAIN | flushed after grant, swallowing the outstanding response
module cpu_instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_valid,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  output logic                  if_req_ready,
  input  logic                  flush,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  imem_err,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_err,
  input  logic                  instr_ready
);

  ifu_state_e            state_q, state_d;
  logic                  imem_req_q, imem_req_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic                  instr_valid_q, instr_valid_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                  instr_err_q, instr_err_d;

  always_comb begin
    state_d       = state_q;
    imem_req_d    = imem_req_q;
    imem_addr_d   = imem_addr_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_err_d   = instr_err_q;

    unique case (state_q)
      IFU_IDLE: begin
        if (if_req_valid && !flush) begin
          instr_pc_d = if_req_addr;
`ifdef CPU_IFU_ALIGN_CHECK_EN
          if (if_req_addr[1:0] != 2'b00) begin
            instr_d       = DATA_WIDTH'(INSTR_NOP);
            instr_err_d   = 1'b1;
            instr_valid_d = 1'b1;
            state_d       = IFU_HOLD;
          end else begin
            imem_addr_d = if_req_addr;
            imem_req_d  = 1'b1;
            state_d     = IFU_REQ;
          end
`else
          imem_addr_d = if_req_addr;
          imem_req_d  = 1'b1;
          state_d     = IFU_REQ;
`endif
        end
      end
      IFU_REQ: begin
        // Grant and rvalid never coincide here, so rvalid is not examined.
        if (imem_gnt) begin
          imem_req_d = 1'b0;
          state_d    = flush ? IFU_DRAIN : IFU_WAIT;
        end else if (flush) begin
          imem_req_d = 1'b0;
          state_d    = IFU_IDLE;
        end
      end
      IFU_WAIT: begin
        if (flush) begin
          state_d = imem_rvalid ? IFU_IDLE : IFU_DRAIN;
        end else if (imem_rvalid) begin
          instr_d       = imem_rdata;
          instr_err_d   = imem_err;
          instr_valid_d = 1'b1;
          state_d       = IFU_HOLD;
        end
      end
      IFU_HOLD: begin
        if (instr_ready || flush) begin
          instr_valid_d = 1'b0;
          state_d       = IFU_IDLE;
        end
      end
      IFU_DRAIN: begin
        if (imem_rvalid) state_d = IFU_IDLE;
      end
      default: begin
        state_d       = IFU_IDLE;
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IFU_IDLE;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_err_q   <= instr_err_d;
    end
  end

  assign if_req_ready = (state_q == IFU_IDLE);
  assign imem_req     = imem_req_q;
  assign imem_addr    = imem_addr_q;
  assign instr_valid  = instr_valid_q;
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign instr_err    = instr_err_q;

endmodule
